// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key-index fields and LFSR constants for the keypad emulator
package keypad_pkg;
   localparam logic [1:0] ST_IDLE           = 2'd0;
   localparam logic [1:0] ST_PRESS_BOUNCE   = 2'd1;
   localparam logic [1:0] ST_HOLD           = 2'd2;
   localparam logic [1:0] ST_RELEASE_BOUNCE = 2'd3;
   typedef enum logic [1:0] {
      IDLE           = ST_IDLE,
      PRESS_BOUNCE   = ST_PRESS_BOUNCE,
      HOLD           = ST_HOLD,
      RELEASE_BOUNCE = ST_RELEASE_BOUNCE
   } state_t;
   localparam logic [3:0] NO_KEY = 4'b0000;
   localparam int KEY_ROW_HI = 3;
   localparam int KEY_ROW_LO = 2;
   localparam int KEY_COL_HI = 1;
   localparam int KEY_COL_LO = 0;
   // taps 8,6,5,4 of the Fibonacci LFSR, as bit positions 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   function automatic logic [3:0] row_onehot(input logic [1:0] r);
      return 4'(4'b0001 << r);
   endfunction
endpackage

// File: rtl/keypad_lfsr8.sv
// keypad_lfsr8: free-running 8-bit Fibonacci LFSR that supplies contact chatter
// ports: clk, rst_n (sync, active-low) in; state [7:0] out, loaded with SEED on reset
module keypad_lfsr8
   import keypad_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] state
);
   // an all-zero seed would lock the LFSR up
   localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= INIT;
      else state <= {state[6:0], ^(state & LFSR_TAPS)};
   end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: scriptable 4x4 matrix keypad with press/release bounce and programmable hold
// ports: clk, rst_n (sync, active-low); cmd_valid/cmd_ready handshake with cmd_key [3:2]=row [1:0]=col
//        and cmd_hold (0 = HOLD_TICKS); keypad_col_in strobe in, keypad_row_out sensed rows out;
//        busy while a sequence runs, done pulses in the first IDLE cycle after it
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int unsigned BOUNCE_TICKS = 8,
   parameter int unsigned HOLD_TICKS   = 200,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_key,
   input  logic [15:0] cmd_hold,
   input  logic [3:0]  keypad_col_in,
   output logic [3:0]  keypad_row_out,
   output logic        busy,
   output logic        done
);
   localparam logic [15:0] B_LEN    = 16'(BOUNCE_TICKS);
   localparam logic [15:0] HOLD_DEF = 16'(HOLD_TICKS);
   logic [7:0]  lfsr;
   logic        unused_lfsr;
   state_t      state, nxt;
   logic [15:0] cnt, hold_len;
   logic [1:0]  row_idx, col_idx;
   logic        contact, last, accept;
   keypad_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .state (lfsr)
   );
   assign unused_lfsr = ^lfsr[7:1];
   always_comb begin
      accept  = cmd_valid && cmd_ready;
      // both bounce states chatter on lfsr[0]; HOLD is solidly closed
      contact = (state == HOLD) || ((state != IDLE) && lfsr[0]);
      // counter restarts at every state entry, so length-1 marks the final cycle
      last    = cnt == (((state == HOLD) ? hold_len : B_LEN) - 16'd1);
      nxt     = (state == IDLE) ? (accept ? ((B_LEN == 16'd0) ? HOLD : PRESS_BOUNCE) : IDLE)
              : !last ? state
              : (state == PRESS_BOUNCE) ? HOLD
              : ((state == HOLD) && (B_LEN != 16'd0)) ? RELEASE_BOUNCE
              : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         cmd_ready      <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         keypad_row_out <= NO_KEY;
         row_idx        <= '0;
         col_idx        <= '0;
         hold_len       <= '0;
      end else begin
         state          <= nxt;
         cnt            <= (nxt != state) ? '0 : cnt + 16'd1;
         cmd_ready      <= nxt == IDLE;
         busy           <= nxt != IDLE;
         done           <= (state != IDLE) && (nxt == IDLE);
         // only the latched column bit matters, so multi-bit strobes still see the key
         keypad_row_out <= (contact && keypad_col_in[col_idx]) ? row_onehot(row_idx) : NO_KEY;
         if (state == IDLE && accept) begin
            row_idx  <= cmd_key[KEY_ROW_HI:KEY_ROW_LO];
            col_idx  <= cmd_key[KEY_COL_HI:KEY_COL_LO];
            hold_len <= (cmd_hold == 16'd0) ? HOLD_DEF : cmd_hold;
         end
      end
   end
endmodule
